data_ram: RTL and testbench
===========================

# data_ram

Data-side memory responder for the core's memory-access stage. It accepts the stage's address, store data, write enable and store width (`wa`), performs byte/half/word writes on the clock edge, and returns the addressed data right-aligned so the stage can sign- or zero-extend from bit 0. After every reset, a clear sequencer zeroes the array one word per cycle before the block accepts writes. Misaligned stores are flagged with a sticky error.

## Interface
- `DEPTH`, 1024, number of 32-bit words; must be a power of two, at least 4.
- `INIT_CLEAR`, 1, 1 = zero the array after reset; 0 = ready immediately, contents undefined.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `addr`  in  32  byte address (the memory stage's `Data_addr`).
- `wdata`  in  32  store data, right-aligned (the stage's `Data_out`).
- `we`  in  1  store request; high for the whole store cycle.
- `wa`  in  2  store width: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `rdata`  out  32  load data returned to the stage (`Data_in`), combinational.
- `ready`  out  1  high when the array is usable and stores are accepted.
- `misalign_err`  out  1  sticky flag; set by a rejected misaligned store.

## Operation
- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap (alias) modulo 4*DEPTH bytes.
- FSM states:
  - CLEAR: an internal counter `cnt` (log2(DEPTH) bits) counts from 0. Each edge writes `mem[cnt]=0` and increments `cnt`. The edge at which `cnt==DEPTH-1` moves the FSM to READY.
  - READY: terminal state; left only by reset.
- Reset state is CLEAR with `cnt=0` when `INIT_CLEAR=1`, and READY when `INIT_CLEAR=0`.
- `ready` = (state==READY).
- Store, committed at the rising edge only when `ready & we & aligned`:
  - `wa=0`: byte lane `addr[1:0]` gets `wdata[7:0]`.
  - `wa=1`: half `addr[1]` gets `wdata[15:0]`.
  - `wa=2/3`: all 4 bytes get `wdata`.
  - Lanes not written keep their old value.
- Alignment rules:
  - `wa=0` is always aligned.
  - `wa=1` requires `addr[0]=0`.
  - `wa>=2` requires `addr[1:0]=0`.
- Misaligned store with `ready & we`: no lane is written, and `misalign_err` is set at that edge. It stays set until reset.
- `we` during CLEAR is ignored: no write, no error.
- Load: `rdata = mem[index] >> (8*addr[1:0])`, with the vacated upper bits zero-filled.
  - lb/lbu and lh/lhu at any legal offset therefore find their data in bits [7:0] / [15:0].
  - lw uses offset 0.
  - Reads carry no alignment check.
- During CLEAR, `rdata` is forced to 0.
- `we` and `wa` are only meaningful while the stage asserts a store. The block must not rely on `wa` being held when `we=0`.

## Timing
- Reset values:
  - `ready=0` (1 if `INIT_CLEAR=0`).
  - `misalign_err=0`.
  - `rdata=0` while in CLEAR.
  - `cnt=0`.
- Clear latency: `ready` rises after exactly DEPTH rising edges following `rst_n` deassertion.
- Store latency: written data is visible on `rdata` in the cycle after the committing edge, combinationally from `addr`.
- Read-during-write to the same word in one cycle: `rdata` shows the old contents until the edge.
- Back-to-back stores on consecutive cycles are each committed; there is no stall and no backpressure in READY.
- Reset asserted mid-CLEAR or mid-store:
  - The FSM returns immediately to CLEAR with `cnt=0`, and `misalign_err` clears.
  - A store in flight at the reset edge is not committed.
  - The clear restarts from word 0.
- `misalign_err` is registered: it rises one edge after the offending store cycle begins.

## Test plan
- Reset with DEPTH=16, then hold `we=1 wa=2 addr=0 wdata=FFFFFFFF` throughout -> `ready` rises after 16 edges; the ignored store is not written, so reading addr 0 then returns 00000000.
- In READY, store word `addr=0x20 wdata=0xAABBCCDD` -> reads give:
  - `addr=0x20`: `rdata=AABBCCDD`.
  - `addr=0x21`: `rdata=00AABBCC`.
  - `addr=0x23`: `rdata=000000AA`.
- Store byte `wa=0 addr=0x22 wdata=0x11`, then store half `wa=1 addr=0x20 wdata=0x5566` -> word read at 0x20 returns `AA115566`.
- Store half at `addr=0x21`, and separately store word at `addr=0x22` -> neither lane changes; `misalign_err` goes 1 after the first and stays 1.
- Store word `0x12345678` to `addr=0x20` with DEPTH=16, then read `addr=0x60` -> `rdata=12345678` (address aliasing).
- Assert `rst_n=0` at CLEAR `cnt=7`, release -> `ready=0` for another 16 edges; `misalign_err=0`; all words read 0.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: data-side memory responder for the core's memory-access stage.
//
// After every reset a clear sequencer zeroes the array one word per cycle.
// The block then accepts byte, half and word stores. Loads return the
// addressed word shifted right by the byte offset, so the stage can extend
// from bit 0. A misaligned store is dropped and sets a sticky error flag.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   INIT_CLEAR   1 = zero the array after reset, 0 = ready immediately
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   addr[31:0]   byte address; upper bits alias modulo 4*DEPTH bytes
//   wdata[31:0]  right-aligned store data
//   we           store request
//   wa[1:0]      store width: 0 byte, 1 half, 2/3 word
//   rdata[31:0]  combinational load data, right-aligned (0 while clearing)
//   ready        array usable and stores accepted
//   misalign_err sticky flag for a rejected misaligned store
module data_ram #(
    parameter int DEPTH      = 1024,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  wa,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;

    // Store is legal when the offset is a multiple of its width.
    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] off);
        logic ok;
        case (width)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~off[0];
            default: ok = (off == 2'd0);
        endcase
        return ok;
    endfunction

    // Byte-enable mask for a store of the given width at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] m;
        case (width)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate narrow data across all lanes; the byte mask picks the lane.
    function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] d);
        logic [31:0] r;
        case (width)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [AW-1:0] idx_s;
    logic          aligned_s;
    logic          store_s;
    logic          bad_store_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_word_s;
    logic          unused_addr_s;

    assign idx_s         = addr[AW+1:2];
    assign unused_addr_s = ^addr[31:AW+2];
    assign aligned_s     = is_aligned(wa, addr[1:0]);
    assign store_s       = (state_q == ST_READY) & we & aligned_s;
    assign bad_store_s   = (state_q == ST_READY) & we & ~aligned_s;

    // Next-state logic for the clear sequencer and the sticky error flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
        if (bad_store_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State, clear counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Single write port shared by the clear sequencer and accepted stores.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = idx_s;
        wr_be_s   = 4'b0000;
        wr_word_s = 32'h0000_0000;
        if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = cnt_q;
            wr_be_s   = 4'b1111;
            wr_word_s = 32'h0000_0000;
        end else if (store_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx_s;
            wr_be_s   = lane_mask(wa, addr[1:0]);
            wr_word_s = lane_data(wa, wdata);
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Byte-lane writes into the array; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_s[b]) begin
                    mem[wr_idx_s][8*b +: 8] <= wr_word_s[8*b +: 8];
                end
            end
        end
    end

    // Load path: right-align the addressed bytes, zero while clearing.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            rdata = 32'h0000_0000;
        end else begin
            rdata = mem[idx_s] >> {addr[1:0], 3'b000};
        end
    end

    assign ready        = (state_q == ST_READY);
    assign misalign_err = err_q;

endmodule

// File: tb/tb_data_ram.sv
// Randomised self-checking bench for data_ram (DEPTH=16) against a
// byte-level reference model of the memory.
module tb_data_ram;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] rdata;
    logic        ready;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_err;

    data_ram #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .wa           (wa),
        .rdata        (rdata),
        .ready        (ready),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off = int'(a % 4);
        logic [31:0] w = model_mem[(a / 4) % DEPTH];
        return w >> (8 * off);
    endfunction

    function automatic bit model_aligned(input logic [31:0] a, input logic [1:0] w);
        if (w == 2'd0) return 1'b1;
        if (w == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        int nbytes = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        int off    = int'(a % 4);
        int i      = int'((a / 4) % DEPTH);
        if (!model_aligned(a, w)) begin
            model_err = 1'b1;
            return;
        end
        for (int k = 0; k < nbytes; k++) begin
            model_mem[i][8*(off+k) +: 8] = d[8*k +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_err = 1'b0;
    endfunction

    // One store cycle: inputs held across a single rising edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        addr = a; wdata = d; wa = w; we = 1'b1;
        @(posedge clk);
        model_store(a, d, w);
        #1;
        we = 1'b0;
    endtask

    // Wait for ready after reset release; returns number of edges seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check_eq(tag, rdata, exp);
    endtask

    initial begin
        int n;
        model_reset();
        rst_n = 1'b0; we = 1'b1; wa = 2'd2; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        #12;
        check_eq("rst_ready", {31'h0, ready}, 32'h0);
        check_eq("rst_err", {31'h0, misalign_err}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);

        // Release just after an edge, store held high throughout the clear.
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("clear_rdata", rdata, 32'h0);
        wait_ready(n);
        check_eq("clear_latency", n + 1, 32'd16);
        check_eq("ignored_store", rdata, 32'h0);
        we = 1'b0;
        check_eq("ready_up_err", {31'h0, misalign_err}, 32'h0);
        for (int i = 0; i < DEPTH; i++) read_chk("cleared_word", 32'(i * 4), 32'h0);

        // Word store, offset reads.
        do_store(32'h20, 32'hAABB_CCDD, 2'd2);
        read_chk("lw_0x20", 32'h20, 32'hAABB_CCDD);
        read_chk("rd_0x21", 32'h21, 32'h00AA_BBCC);
        read_chk("rd_0x23", 32'h23, 32'h0000_00AA);

        // Byte then half merge.
        do_store(32'h22, 32'h0000_0011, 2'd0);
        do_store(32'h20, 32'h0000_5566, 2'd1);
        read_chk("merge_0x20", 32'h20, 32'hAA11_5566);

        // Misaligned stores leave the word untouched, error sticks.
        do_store(32'h21, 32'h0000_9999, 2'd1);
        check_eq("misalign_half_err", {31'h0, misalign_err}, 32'h1);
        read_chk("misalign_half_data", 32'h20, 32'hAA11_5566);
        do_store(32'h22, 32'h7777_7777, 2'd2);
        check_eq("misalign_word_err", {31'h0, misalign_err}, 32'h1);
        read_chk("misalign_word_data", 32'h20, 32'hAA11_5566);

        // Read-during-write shows old data, then aliasing read.
        addr = 32'h20; wdata = 32'h1234_5678; wa = 2'd3; we = 1'b1;
        #1;
        check_eq("rdw_old", rdata, 32'hAA11_5566);
        @(posedge clk);
        model_store(32'h20, 32'h1234_5678, 2'd3);
        #1;
        we = 1'b0;
        read_chk("alias_0x60", 32'h60, 32'h1234_5678);

        // Randomised back-to-back traffic against the model.
        for (int c = 0; c < 400; c++) begin
            addr  = $urandom();
            wdata = $urandom();
            wa    = 2'($urandom_range(0, 3));
            we    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            #1;
            check_eq("rand_rdata", rdata, model_read(addr));
            check_eq("rand_err", {31'h0, misalign_err}, {31'h0, model_err});
            @(posedge clk);
            if (we) model_store(addr, wdata, wa);
            #1;
        end
        we = 1'b0;
        for (int i = 0; i < DEPTH; i++) read_chk("rand_final", 32'(i * 4), model_mem[i]);

        // Reset mid-store: error clears asynchronously, store not committed.
        addr = 32'h8; wdata = 32'hDEAD_BEEF; wa = 2'd2; we = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_err", {31'h0, misalign_err}, 32'h0);
        check_eq("midrst_ready", {31'h0, ready}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
        check_eq("clear_cnt7_ready", {31'h0, ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_cnt7_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wait_ready(n);
        check_eq("restart_latency", n + 1, 32'd16);
        we = 1'b0;
        check_eq("restart_err", {31'h0, misalign_err}, 32'h0);
        for (int i = 0; i < DEPTH; i++) read_chk("restart_zero", 32'(i * 4), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
